pipe_hazard_ctrl: RTL
=====================

# pipe_hazard_ctrl

Parametrised hazard-detection and control-flow sequencer for the 5-stage MIPS pipeline, sitting between ID and the PC/IF-ID register controls. It detects load-use RAW hazards and drives PC write enable, IF/ID write enable, ID/EX bubble insertion and next-PC source select. Load-use stall length and branch-resolution depth are configurable. An external freeze input serves multi-cycle memory, and an optional stall-cycle performance counter can be compiled in.

## Interface
Parameters:
- REG_AW, 5, register address width.
- LOAD_STALL, 1, bubble cycles per load-use hazard; legal 1..3.
- BR_WAIT, 1, stall cycles after a branch issues before ALUZero is sampled; legal 1..2.

Ports:
- Clk  in  1  pipeline clock; all state updates on rising edge.
- Rst  in  1  asynchronous, active-low reset.
- Freeze  in  1  external stall from a memory wait; holds state and counters.
- Jump  in  1  jump decoded in ID.
- Branch  in  1  conditional branch decoded in ID.
- ALUZero  in  1  branch condition from EX; valid in the sampling cycle.
- memReadEX  in  1  instruction in EX is a load.
- UseImmed  in  1  ID instruction uses an immediate operand.
- UseShmt  in  1  ID instruction uses shamt.
- CurrRs, CurrRt  in  REG_AW  ID source registers.
- PrevRw  in  REG_AW  EX destination register.
- PC_Write  out  1  PC update enable.
- IF_Write  out  1  IF/ID register write enable.
- bubble  out  1  zero the ID/EX control word.
- addrSel  out  2  next-PC source: 00 PC+4, 01 jump target, 10 branch target, 11 unused.

## Operation
- Load hazard (combinational): LoadHazard=1 only when PrevRw≠0 and memReadEX=1, plus one of the following:
  - !UseImmed & !UseShmt: CurrRs==PrevRw or CurrRt==PrevRw.
  - UseShmt & !UseImmed: CurrRs==PrevRw.
  - UseImmed & !UseShmt: CurrRs==PrevRw.
  - Both set: no hazard.
- States: IDLE, LOAD, JUMP, BR_WAIT, BR_TAKEN. 2-bit counter `cnt`.
- IDLE priority is Jump > LoadHazard > Branch > none.
  - Jump: outputs pass (1,1,0,00); next state JUMP.
  - LoadHazard: outputs stall (PC_Write=0, IF_Write=0, bubble=1, addrSel=00). If LOAD_STALL=1, stay IDLE. Otherwise go to LOAD with cnt=LOAD_STALL-2.
  - Branch: outputs pass; next state BR_WAIT with cnt=BR_WAIT-1.
  - None: outputs pass; stay IDLE.
- LOAD: outputs stall. If cnt==0, go to IDLE; otherwise cnt-1. Hazard inputs are ignored while in LOAD.
- JUMP: PC_Write=1, IF_Write=0, bubble=1, addrSel=01; next state IDLE.
- BR_WAIT: outputs stall.
  - If cnt≠0: cnt-1.
  - If cnt==0, sample ALUZero. ALUZero=1 goes to BR_TAKEN; ALUZero=0 goes to IDLE.
- BR_TAKEN: PC_Write=1, IF_Write=0, bubble=1, addrSel=10; next state IDLE.
- Freeze=1 overrides every state:
  - PC_Write=0, IF_Write=0, bubble=0, addrSel=00.
  - State, cnt and the perf counter hold.
  - Jump/Branch/LoadHazard are not consumed.
- An illegal state encoding forces all outputs to 0, with next state IDLE.

## Timing
- Rst low: state=IDLE, cnt=0, perf counter=0, asynchronously. Outputs are therefore PC_Write=1, IF_Write=1, bubble=0, addrSel=00 while no hazard inputs are asserted.
- Rst deasserted mid-sequence: the next edge proceeds from IDLE; any pending branch or jump is abandoned.
- Outputs are combinational from state and inputs, with zero-cycle detect-to-stall latency.
- Load-use stall: exactly LOAD_STALL consecutive bubble cycles.
- Jump: 1 penalty cycle.
- Branch not taken: BR_WAIT stall cycles.
- Branch taken: BR_WAIT+1 cycles.
- Freeze cycles stretch any sequence 1:1.

## Configuration
- HAZARD_PERF_EN defined:
  - Adds output StallCount (out, 16 bits): count of cycles with bubble=1 and Freeze=0.
  - Saturates at 16'hFFFF and resets to 0.
- HAZARD_PERF_EN undefined: the port and counter are absent, and behaviour is otherwise identical.

## Test plan
- Reset then idle: Rst=0→1 with all inputs 0 → PC_Write=1, IF_Write=1, bubble=0, addrSel=00 every cycle.
- Load-use with LOAD_STALL=2: memReadEX=1, PrevRw=8, CurrRt=8, UseImmed=0, UseShmt=0 → bubble=1 with PC_Write=IF_Write=0 for exactly 2 cycles, then pass. PrevRw=0 with the same registers → no stall. UseImmed=1 with only CurrRt=8 → no stall.
- Jump: Jump=1 for one cycle → pass that cycle, then 1 cycle with addrSel=01, PC_Write=1, IF_Write=0, bubble=1, then IDLE.
- Branch with BR_WAIT=2, ALUZero=1 on the sampling cycle → 2 stall cycles, then addrSel=10 with PC_Write=1 for 1 cycle. Repeat with ALUZero=0 → 2 stalls, then back to IDLE with addrSel=00.
- Priority and freeze:
  - Jump=1 and a load hazard in the same cycle → jump sequence, no load stall.
  - Freeze=1 for 3 cycles mid-BR_WAIT → all enables 0, sequence resumes unchanged afterward.
- HAZARD_PERF_EN: one load stall (LOAD_STALL=1) plus one taken branch (BR_WAIT=1) → StallCount=3. Preload near saturation → holds at 16'hFFFF.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl
//
// Hazard-detection and control-flow sequencer for a 5-stage MIPS pipeline.
// Sits between ID and the PC / IF-ID register controls.
//
// It detects load-use RAW hazards and sequences the stall and redirect
// cycles that follow a hazard, a jump or a conditional branch.
//
// Parameters
//   REG_AW      register address width
//   LOAD_STALL  bubble cycles per load-use hazard (1..3)
//   BR_WAIT     stall cycles before ALUZero is sampled (1..2)
//
// Ports
//   Clk, Rst               clock; asynchronous active-low reset
//   Freeze                 external memory stall; holds all state
//   Jump, Branch           control transfer decoded in ID
//   ALUZero                branch condition from EX
//   memReadEX              EX instruction is a load
//   UseImmed, UseShmt      ID operand usage (which sources are read)
//   CurrRs, CurrRt         ID source registers
//   PrevRw                 EX destination register
//   PC_Write, IF_Write     PC / IF-ID write enables
//   bubble                 zero the ID/EX control word
//   addrSel                next PC: 00 PC+4, 01 jump, 10 branch
//   StallCount             (HAZARD_PERF_EN only) saturating count of
//                          unfrozen bubble cycles
//
// Compile-time option: define HAZARD_PERF_EN to add StallCount.
// ---------------------------------------------------------------------------
module pipe_hazard_ctrl #(
    parameter int REG_AW     = 5,
    parameter int LOAD_STALL = 1,
    parameter int BR_WAIT    = 1
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              Freeze,
    input  logic              Jump,
    input  logic              Branch,
    input  logic              ALUZero,
    input  logic              memReadEX,
    input  logic              UseImmed,
    input  logic              UseShmt,
    input  logic [REG_AW-1:0] CurrRs,
    input  logic [REG_AW-1:0] CurrRt,
    input  logic [REG_AW-1:0] PrevRw,
    output logic              PC_Write,
    output logic              IF_Write,
    output logic              bubble,
    output logic [1:0]        addrSel
`ifdef HAZARD_PERF_EN
    ,
    output logic [15:0]       StallCount
`endif
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_LOAD     = 3'd1,
        S_JUMP     = 3'd2,
        S_BR_WAIT  = 3'd3,
        S_BR_TAKEN = 3'd4
    } state_e;

    // The IDLE cycle itself supplies the first load bubble, so LOAD covers
    // the remaining LOAD_STALL-1 cycles and counts down to zero.
    localparam logic [1:0] LOAD_CNT_INIT = 2'(LOAD_STALL - 2);
    localparam logic [1:0] BR_CNT_INIT   = 2'(BR_WAIT - 1);

    state_e     state_q, state_d;
    logic [1:0] cnt_q, cnt_d;
    logic       load_hazard;
    logic       rs_hit, rt_hit, src_hit;

    // ---------------------------------------------------------------------
    // Load-use hazard: only the sources the ID instruction actually reads
    // are compared; r0 is never a real dependency.
    // ---------------------------------------------------------------------
    assign rs_hit = (CurrRs == PrevRw);
    assign rt_hit = (CurrRt == PrevRw);

    always_comb begin
        // NOTE: every signal written in a combinational block gets a default
        // first, otherwise an unassigned path infers a latch.
        src_hit = 1'b0;
        case ({UseImmed, UseShmt})
            2'b00:        src_hit = rs_hit | rt_hit;
            2'b01, 2'b10: src_hit = rs_hit;
            default:      src_hit = 1'b0;
        endcase
    end

    assign load_hazard = memReadEX && (PrevRw != '0) && src_hit;

    // ---------------------------------------------------------------------
    // State register
    // ---------------------------------------------------------------------
    always_ff @(posedge Clk or negedge Rst) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (!Rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // ---------------------------------------------------------------------
    // Next state and outputs
    // ---------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        PC_Write = 1'b1;
        IF_Write = 1'b1;
        bubble   = 1'b0;
        addrSel  = 2'b00;

        if (Freeze) begin
            // Memory wait: nothing advances and no request is consumed.
            PC_Write = 1'b0;
            IF_Write = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (Jump) begin
                        state_d = S_JUMP;
                    end else if (load_hazard) begin
                        PC_Write = 1'b0;
                        IF_Write = 1'b0;
                        bubble   = 1'b1;
                        if (LOAD_STALL > 1) begin
                            state_d = S_LOAD;
                            cnt_d   = LOAD_CNT_INIT;
                        end
                    end else if (Branch) begin
                        state_d = S_BR_WAIT;
                        cnt_d   = BR_CNT_INIT;
                    end
                end
                S_LOAD: begin
                    PC_Write = 1'b0;
                    IF_Write = 1'b0;
                    bubble   = 1'b1;
                    if (cnt_q == 2'd0) state_d = S_IDLE;
                    else               cnt_d   = cnt_q - 2'd1;
                end
                S_JUMP: begin
                    IF_Write = 1'b0;
                    bubble   = 1'b1;
                    addrSel  = 2'b01;
                    state_d  = S_IDLE;
                end
                S_BR_WAIT: begin
                    PC_Write = 1'b0;
                    IF_Write = 1'b0;
                    bubble   = 1'b1;
                    if (cnt_q != 2'd0) cnt_d   = cnt_q - 2'd1;
                    else if (ALUZero)  state_d = S_BR_TAKEN;
                    else               state_d = S_IDLE;
                end
                S_BR_TAKEN: begin
                    IF_Write = 1'b0;
                    bubble   = 1'b1;
                    addrSel  = 2'b10;
                    state_d  = S_IDLE;
                end
                default: begin
                    // Unreachable encodings: drive everything low and recover.
                    PC_Write = 1'b0;
                    IF_Write = 1'b0;
                    state_d  = S_IDLE;
                end
            endcase
        end
    end

`ifdef HAZARD_PERF_EN
    // ---------------------------------------------------------------------
    // Saturating stall counter (bubble is already 0 whenever Freeze is 1)
    // ---------------------------------------------------------------------
    logic [15:0] stall_cnt_q;

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            stall_cnt_q <= 16'd0;
        end else if (bubble && !Freeze && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end

    assign StallCount = stall_cnt_q;
`endif

endmodule
